// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache in front of a block-granular
// memory that takes one request at a time over a valid/ready channel.
module data_cache #(
    parameter int NUM_SETS   = 16,
    parameter int BLOCK_SIZE = 16,
    parameter int WORD_SIZE  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_rw,
    input  logic [31:0]             din,
    output logic                    is_ready,
    output logic                    is_output_valid,
    output logic [31:0]             dout,
    output logic                    is_hit,
    output logic                    mem_is_input_valid,
    output logic [31:0]             mem_addr,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [BLOCK_SIZE*8-1:0] mem_din,
    input  logic                    mem_is_output_valid,
    input  logic [BLOCK_SIZE*8-1:0] mem_dout,
    input  logic                    mem_ready
);
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WORDS  = BLOCK_SIZE / WORD_SIZE;
    localparam int WSEL_W = $clog2(WORDS);
    localparam int LINE_W = BLOCK_SIZE * 8;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE} state_t;

    state_t              state_q, state_d;
    logic                issued_q, issued_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WSEL_W-1:0]   req_wsel;
    logic [TAG_W-1:0]    cur_tag;
    logic [LINE_W-1:0]   cur_line;
    logic [LINE_W-1:0]   merged_line;
    logic [LINE_W-1:0]   line_data_d;
    logic [31:0]         cur_word;
    logic                cur_hit;
    logic                line_we;
    logic                unused_addr_bits;

    assign req_tag          = addr[31 -: TAG_W];
    assign req_idx          = addr[OFF_W +: IDX_W];
    assign req_wsel         = addr[2 +: WSEL_W];
    assign unused_addr_bits = ^addr[1:0];

    // The CPU holds its address during a miss, so req_idx also selects the victim line.
    assign cur_tag  = tag_q[req_idx];
    assign cur_line = data_q[req_idx];
    assign cur_word = cur_line[{req_wsel, 5'd0} +: 32];
    assign cur_hit  = valid_q[req_idx] && (cur_tag == req_tag);

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_merge
            assign merged_line[gi*32 +: 32] =
                (req_wsel == WSEL_W'(gi)) ? din : cur_line[gi*32 +: 32];
        end
    endgenerate

    always_comb begin
        state_d            = state_q;
        issued_d           = issued_q;
        valid_d            = valid_q;
        dirty_d            = dirty_q;
        line_we            = 1'b0;
        line_data_d        = cur_line;
        is_ready           = 1'b0;
        is_output_valid    = 1'b0;
        is_hit             = 1'b0;
        dout               = 32'd0;
        mem_is_input_valid = 1'b0;
        mem_addr           = 32'd0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_din            = '0;

        case (state_q)
            IDLE: begin
                is_ready = 1'b1;
                if (is_input_valid) begin
                    if (cur_hit) begin
                        is_hit          = 1'b1;
                        is_output_valid = 1'b1;
                        if (mem_rw) begin
                            line_we          = 1'b1;
                            line_data_d      = merged_line;
                            dirty_d[req_idx] = 1'b1;
                        end else begin
                            dout = cur_word;
                        end
                    end else begin
                        issued_d = 1'b0;
                        state_d  = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITE_BACK : ALLOCATE;
                    end
                end
            end

            WRITE_BACK: begin
                if (!issued_q) begin
                    if (mem_ready) begin
                        mem_is_input_valid = 1'b1;
                        mem_write          = 1'b1;
                        mem_addr           = 32'({cur_tag, req_idx});
                        mem_din            = cur_line;
                        issued_d           = 1'b1;
                    end
                end else if (mem_ready) begin
                    // Memory has absorbed the victim; the fetch can go out next cycle.
                    issued_d = 1'b0;
                    state_d  = ALLOCATE;
                end
            end

            ALLOCATE: begin
                if (!issued_q) begin
                    if (mem_ready) begin
                        mem_is_input_valid = 1'b1;
                        mem_read           = 1'b1;
                        mem_addr           = 32'({req_tag, req_idx});
                        issued_d           = 1'b1;
                    end
                end else if (mem_is_output_valid) begin
                    line_we          = 1'b1;
                    line_data_d      = mem_dout;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    issued_d         = 1'b0;
                    state_d          = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                issued_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            issued_q <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[req_idx] <= line_data_d;
            tag_q[req_idx]  <= req_tag;
        end
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and the block-granular delayed data memory (its downstream neighbour).
- Serves 32-bit word loads and stores from the CPU.
- On a miss, writes back a dirty victim block and fetches the missing block over the memory's valid/ready request interface.

Parameters:
- NUM_SETS, 16, number of cache lines; power of two.
- BLOCK_SIZE, 16, bytes per line; must equal the data memory BLOCK_SIZE (4 words).
- WORD_SIZE, 4, bytes per CPU word.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- is_input_valid  input  1  CPU request valid.
- addr  input  32  CPU byte address; bits [1:0] ignored.
- mem_rw  input  1  0 = read, 1 = write.
- din  input  32  CPU write data.
- is_ready  output  1  cache idle and able to accept or retry a request.
- is_output_valid  output  1  CPU request completed this cycle (read data valid).
- dout  output  32  read data.
- is_hit  output  1  current accepted request hits.
- mem_is_input_valid  output  1  request to data memory.
- mem_addr  output  32  block address, i.e. byte address >> log2(BLOCK_SIZE).
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- mem_din  output  BLOCK_SIZE*8  victim block data.
- mem_is_output_valid  input  1  memory read data valid.
- mem_dout  input  BLOCK_SIZE*8  fetched block data.
- mem_ready  input  1  memory idle; a request is accepted only while high.

Behaviour:
- Address split (defaults): word offset [3:2], index [7:4], tag [31:8]. General form: index width log2(NUM_SETS), tag = remaining upper bits.
- Per line storage: valid, dirty, tag, BLOCK_SIZE*8 data.
- Reset (reset = 0, async): all valid and dirty bits cleared; state = IDLE; every output = 0 except is_ready = 1. Data/tag arrays need no clearing. Reset mid-miss abandons the fill; the victim line stays invalid or unchanged.
- States: IDLE, WRITE_BACK, ALLOCATE.
- IDLE:
  - is_ready = 1. Lookup is combinational: hit = valid[index] && tag match.
  - is_input_valid && hit: is_hit = 1 and is_output_valid = 1 in the same cycle (zero-latency hit).
  - Read hit: dout = selected word.
  - Write hit: word written at the clock edge, dirty set; dout = 0.
  - is_input_valid && miss: is_hit = 0, is_output_valid = 0. Next state is WRITE_BACK if the victim is valid && dirty, else ALLOCATE.
  - The CPU holds addr/mem_rw/din stable until is_output_valid.
- WRITE_BACK:
  - is_ready = 0.
  - First cycle with mem_ready = 1 and the write not yet issued: assert mem_is_input_valid = 1 and mem_write = 1 for exactly one cycle, with mem_addr = {victim tag, index} and mem_din = victim block. Set internal flag issued.
  - After issued, wait for mem_ready = 1, then go to ALLOCATE and clear issued.
- ALLOCATE:
  - First cycle with mem_ready = 1: one-cycle mem_is_input_valid = 1 and mem_read = 1, with mem_addr = {req tag, index}.
  - On mem_is_output_valid: line data = mem_dout, tag = req tag, valid = 1, dirty = 0; go to IDLE.
  - The retried request then hits; a write is merged at that point.
- Memory outputs are 0 whenever no request is being issued; mem_read and mem_write are never both 1.
- Latency with memory DELAY = 50, request presented in cycle 0:
  - Clean miss: issue in cycle 1, fill in cycle 52, hit response in cycle 53.
  - Dirty miss: writeback issued in cycle 1, read issued in cycle 53, fill in cycle 104, response in cycle 105.
- is_input_valid = 0 in IDLE: no state change, outputs 0.

Test Plan:
- Reset, then read 0x0000_0040 -> miss, one mem read at block 0x4, response in cycle 53 with dout = 0, is_hit = 1 on the response cycle, valid[4] = 1.
- Write 0xDEAD_BEEF to 0x44, then read 0x44 -> both hit in 0 cycles, read dout = 0xDEAD_BEEF, dirty[4] = 1.
- Read 0x144 (same index, different tag) -> writeback to block 0x4 with mem_din word1 = 0xDEAD_BEEF, then read of block 0x14, response in cycle 105.
- Read 0x44 again -> miss (clean victim, no writeback), dout = 0xDEAD_BEEF fetched from memory.
- Hold mem_ready low for 10 extra cycles during ALLOCATE -> no mem request issued until mem_ready = 1; mem_is_input_valid asserts exactly one cycle.
- Assert reset during WRITE_BACK wait -> state IDLE, is_ready = 1, all valid = 0 immediately (async); next access misses.
